// File: rtl/rob_ctrl.sv
// Reorder-buffer control: hands out ROB ids at decode, records completion and
// retires strictly in program order, flushing on an excepting or illegal head.
module rob_ctrl #(
    parameter int unsigned ROB_DEPTH = 16,
    parameter int unsigned REG_W     = 5,
    localparam int unsigned ROB      = $clog2(ROB_DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dec_e_,
    input  logic             dec_invalid,
    input  logic [REG_W-1:0] dec_rd,
    output logic [ROB-1:0]   dec_rob_id,
    output logic             rob_busy,
    input  logic             exe_e_,
    input  logic [ROB-1:0]   exe_rob_id,
    input  logic             exe_exp,
    output logic             commit_e_,
    output logic [ROB-1:0]   com_rob_id,
    output logic [REG_W-1:0] com_rd,
    output logic             flush_
);

    logic [ROB_DEPTH-1:0] valid_q, valid_d;
    logic [ROB_DEPTH-1:0] done_q, done_d;
    logic [ROB_DEPTH-1:0] exp_q, exp_d;
    logic [REG_W-1:0]     rd_q [ROB_DEPTH];
    logic [REG_W-1:0]     rd_d [ROB_DEPTH];
    logic [ROB-1:0]       head_q, head_d;
    logic [ROB-1:0]       tail_q, tail_d;
    logic [ROB:0]         count_q, count_d;
    logic                 commit_e_q, commit_e_d;
    logic                 flush_q, flush_d;
    logic [ROB-1:0]       com_rob_id_q, com_rob_id_d;
    logic [REG_W-1:0]     com_rd_q, com_rd_d;

    logic head_fire;
    logic flush_fire;
    logic alloc;
    logic cpl;

    // Retirement looks only at registered state, so a completion needs one edge to land.
    assign head_fire  = valid_q[head_q] && done_q[head_q];
    assign flush_fire = head_fire && exp_q[head_q];
    assign rob_busy   = (count_q == (ROB+1)'(ROB_DEPTH)) || flush_fire;
    assign alloc      = !dec_e_ && !rob_busy;
    assign cpl        = !exe_e_ && valid_q[exe_rob_id];

    assign dec_rob_id = tail_q;
    assign commit_e_  = commit_e_q;
    assign flush_     = flush_q;
    assign com_rob_id = com_rob_id_q;
    assign com_rd     = com_rd_q;

    always_comb begin
        valid_d      = valid_q;
        done_d       = done_q;
        exp_d        = exp_q;
        rd_d         = rd_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        commit_e_d   = !head_fire;
        flush_d      = !flush_fire;
        com_rob_id_d = com_rob_id_q;
        com_rd_d     = com_rd_q;

        if (head_fire) begin
            com_rob_id_d = head_q;
            com_rd_d     = rd_q[head_q];
        end

        if (flush_fire) begin
            // Everything younger than the faulting head is squashed, including this cycle's requests.
            valid_d = '0;
            done_d  = '0;
            exp_d   = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (cpl) begin
                done_d[exe_rob_id] = 1'b1;
                exp_d[exe_rob_id]  = exp_q[exe_rob_id] | exe_exp;
            end
            if (head_fire) begin
                valid_d[head_q] = 1'b0;
                head_d          = head_q + ROB'(1);
            end
            if (alloc) begin
                valid_d[tail_q] = 1'b1;
                done_d[tail_q]  = dec_invalid;
                exp_d[tail_q]   = dec_invalid;
                rd_d[tail_q]    = dec_rd;
                tail_d          = tail_q + ROB'(1);
            end
            unique case ({alloc, head_fire})
                2'b10:   count_d = count_q + (ROB+1)'(1);
                2'b01:   count_d = count_q - (ROB+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q      <= '0;
            done_q       <= '0;
            exp_q        <= '0;
            for (int i = 0; i < int'(ROB_DEPTH); i++) rd_q[i] <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            commit_e_q   <= 1'b1;
            flush_q      <= 1'b1;
            com_rob_id_q <= '0;
            com_rd_q     <= '0;
        end else begin
            valid_q      <= valid_d;
            done_q       <= done_d;
            exp_q        <= exp_d;
            rd_q         <= rd_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            commit_e_q   <= commit_e_d;
            flush_q      <= flush_d;
            com_rob_id_q <= com_rob_id_d;
            com_rd_q     <= com_rd_d;
        end
    end

endmodule

// File: tb/tb_rob_ctrl.sv
// Directed bench for rob_ctrl (ROB_DEPTH=16): allocation, in-order retire, wrap,
// flush on illegal/excepting head, and asynchronous reset mid-pulse.
module tb_rob_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       dec_e_;
    logic       dec_invalid;
    logic [4:0] dec_rd;
    logic [3:0] dec_rob_id;
    logic       rob_busy;
    logic       exe_e_;
    logic [3:0] exe_rob_id;
    logic       exe_exp;
    logic       commit_e_;
    logic [3:0] com_rob_id;
    logic [4:0] com_rd;
    logic       flush_;

    int n_tests = 0;
    int n_fail  = 0;

    rob_ctrl #(.ROB_DEPTH(16), .REG_W(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .dec_e_      (dec_e_),
        .dec_invalid (dec_invalid),
        .dec_rd      (dec_rd),
        .dec_rob_id  (dec_rob_id),
        .rob_busy    (rob_busy),
        .exe_e_      (exe_e_),
        .exe_rob_id  (exe_rob_id),
        .exe_exp     (exe_exp),
        .commit_e_   (commit_e_),
        .com_rob_id  (com_rob_id),
        .com_rd      (com_rd),
        .flush_      (flush_)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        dec_e_      = 1'b1;
        dec_invalid = 1'b0;
        dec_rd      = '0;
        exe_e_      = 1'b1;
        exe_rob_id  = '0;
        exe_exp     = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic alloc(input logic [4:0] rd, input logic inv);
        dec_e_      = 1'b0;
        dec_rd      = rd;
        dec_invalid = inv;
        tick();
        dec_e_      = 1'b1;
        dec_invalid = 1'b0;
    endtask

    task automatic complete(input logic [3:0] id, input logic ex);
        exe_e_     = 1'b0;
        exe_rob_id = id;
        exe_exp    = ex;
        tick();
        exe_e_     = 1'b1;
        exe_exp    = 1'b0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        #2;
        check("rst_commit_e", 32'(commit_e_), 32'd1);
        check("rst_flush", 32'(flush_), 32'd1);
        check("rst_com_rob_id", 32'(com_rob_id), 32'd0);
        check("rst_com_rd", 32'(com_rd), 32'd0);
        check("rst_dec_rob_id", 32'(dec_rob_id), 32'd0);
        check("rst_busy", 32'(rob_busy), 32'd0);
        tick();
        reset = 1'b0;

        // 1: single alloc, complete, commit one cycle after done lands
        do_reset();
        dec_e_ = 1'b0;
        dec_rd = 5'd1;
        #1;
        check("t1_dec_id", 32'(dec_rob_id), 32'd0);
        tick();
        dec_e_ = 1'b1;
        complete(4'd0, 1'b0);
        check("t1_no_early_commit", 32'(commit_e_), 32'd1);
        tick();
        check("t1_commit", 32'(commit_e_), 32'd0);
        check("t1_com_id", 32'(com_rob_id), 32'd0);
        check("t1_com_rd", 32'(com_rd), 32'd1);
        check("t1_flush", 32'(flush_), 32'd1);
        tick();
        check("t1_pulse_end", 32'(commit_e_), 32'd1);

        // 2: fill, refuse 17th, free one, wrap
        do_reset();
        for (int i = 0; i < 16; i++) begin
            check("t2_dec_id", 32'(dec_rob_id), 32'(i));
            check("t2_not_busy", 32'(rob_busy), 32'd0);
            alloc(5'(i + 1), 1'b0);
        end
        check("t2_full_busy", 32'(rob_busy), 32'd1);
        alloc(5'd31, 1'b0);
        check("t2_refused_tail", 32'(dec_rob_id), 32'd0);
        check("t2_still_busy", 32'(rob_busy), 32'd1);
        complete(4'd0, 1'b0);
        check("t2_busy_before_commit", 32'(rob_busy), 32'd1);
        tick();
        check("t2_commit", 32'(commit_e_), 32'd0);
        check("t2_com_id", 32'(com_rob_id), 32'd0);
        check("t2_com_rd", 32'(com_rd), 32'd1);
        check("t2_busy_freed", 32'(rob_busy), 32'd0);
        check("t2_wrap_id", 32'(dec_rob_id), 32'd0);

        // 3: out-of-order completion, in-order retire
        do_reset();
        alloc(5'd3, 1'b0);
        alloc(5'd4, 1'b0);
        alloc(5'd5, 1'b0);
        complete(4'd2, 1'b0);
        check("t3_no_commit_a", 32'(commit_e_), 32'd1);
        complete(4'd1, 1'b0);
        check("t3_no_commit_b", 32'(commit_e_), 32'd1);
        complete(4'd0, 1'b0);
        check("t3_no_commit_c", 32'(commit_e_), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_commit", 32'(commit_e_), 32'd0);
            check("t3_com_id", 32'(com_rob_id), 32'(i));
            check("t3_com_rd", 32'(com_rd), 32'(i + 3));
        end
        tick();
        check("t3_done", 32'(commit_e_), 32'd1);

        // 4: illegal instruction behind a normal one flushes on its retire
        do_reset();
        alloc(5'd7, 1'b0);
        alloc(5'd8, 1'b1);
        complete(4'd0, 1'b0);
        tick();
        check("t4_commit0", 32'(commit_e_), 32'd0);
        check("t4_com_id0", 32'(com_rob_id), 32'd0);
        check("t4_no_flush0", 32'(flush_), 32'd1);
        check("t4_busy_flush_cycle", 32'(rob_busy), 32'd1);
        tick();
        check("t4_commit1", 32'(commit_e_), 32'd0);
        check("t4_com_id1", 32'(com_rob_id), 32'd1);
        check("t4_com_rd1", 32'(com_rd), 32'd8);
        check("t4_flush", 32'(flush_), 32'd0);
        check("t4_tail_reset", 32'(dec_rob_id), 32'd0);
        check("t4_empty", 32'(rob_busy), 32'd0);
        tick();
        check("t4_flush_end", 32'(flush_), 32'd1);

        // 5: exception reported at execute; alloc during the flush cycle is dropped
        do_reset();
        alloc(5'd9, 1'b0);
        complete(4'd0, 1'b1);
        dec_e_ = 1'b0;
        dec_rd = 5'd10;
        #1;
        check("t5_busy", 32'(rob_busy), 32'd1);
        check("t5_dec_id_pre", 32'(dec_rob_id), 32'd1);
        tick();
        dec_e_ = 1'b1;
        check("t5_commit", 32'(commit_e_), 32'd0);
        check("t5_flush", 32'(flush_), 32'd0);
        check("t5_com_rd", 32'(com_rd), 32'd9);
        check("t5_tail_reset", 32'(dec_rob_id), 32'd0);
        complete(4'd0, 1'b0);
        tick();
        check("t5_no_stale_commit", 32'(commit_e_), 32'd1);
        check("t5_dec_id_post", 32'(dec_rob_id), 32'd0);

        // 6: asynchronous reset cancels an in-flight commit pulse
        do_reset();
        alloc(5'd2, 1'b0);
        complete(4'd0, 1'b0);
        tick();
        check("t6_commit_before", 32'(commit_e_), 32'd0);
        reset = 1'b1;
        #1;
        check("t6_commit_cleared", 32'(commit_e_), 32'd1);
        check("t6_flush_cleared", 32'(flush_), 32'd1);
        check("t6_dec_id", 32'(dec_rob_id), 32'd0);
        check("t6_com_rd", 32'(com_rd), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
